// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, PC step and the
// opcode values also consumed by the controller.
package fetch_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_INCR = 4;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LW    = 7'b0000011;
  localparam logic [6:0] OPC_SW    = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO with flush; head is read combinationally from the
// storage registers. Writes to a full FIFO and reads from an empty one are ignored.
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok, rd_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_ok   = wr_en && (count_q != CNT_W'(DEPTH));
  assign rd_ok   = rd_en && (count_q != '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, memory request channel, instruction buffer and
// redirect/halt handling. Optional perf counters under `FETCH_PERF_CNT_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] occ, outstanding;
  logic [CNT_W:0]   inflight;
  logic             req_fire, rsp_keep, pop;
  logic [XLEN-1:0]  rsp_pc;
  logic [XLEN+31:0] head;

  // Request valid is qualified by rst_n so the channel is idle while reset is held.
  assign inflight       = {1'b0, outstanding} + {1'b0, occ};
  assign imem_req_valid = rst_n && (state_q == RUN) && !redirect_valid &&
                          (inflight < (CNT_W + 1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid  = (occ != '0);
  assign pop       = id_valid && id_ready && !redirect_valid;
  assign rsp_keep  = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
  assign id_instr  = id_valid ? head[31:0] : '0;
  assign id_pc     = id_valid ? head[XLEN+31:32] : '0;
  assign id_opcode = id_instr[6:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if (halt) state_d = HALTED;
    if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old path.
      pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
      discard_d = outstanding - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(PC_INCR);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  // Issued addresses in order; its fill level is the outstanding-request count.
  fetch_buf #(.DEPTH(BUF_DEPTH), .WIDTH(XLEN)) u_addr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (1'b0),
    .wr_en   (req_fire),
    .rd_en   (imem_rsp_valid),
    .wr_data (pc_q),
    .rd_data (rsp_pc),
    .count   (outstanding)
  );

  fetch_buf #(.DEPTH(BUF_DEPTH), .WIDTH(XLEN + 32)) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (rsp_keep),
    .rd_en   (pop),
    .wr_data ({rsp_pc, imem_rsp_data}),
    .rd_data (head),
    .count   (occ)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(id_valid && id_ready);
    perf_stall_d   = perf_stall_q + 32'((state_q == RUN) && id_ready && !id_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid, halt;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ((a ^ 32'hA5A5_0000) * 32'h9E37_79B1) + 32'h13;
  endfunction

  // Reference model: program-order PC, pending memory requests, buffered instructions.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend[$];
  logic [31:0] mbuf[$];
  logic [31:0] mpc;
  bit          halted;
  int          cyc, last_due, lat_min, lat_max;
  int          n_hs;
  bit          mark, seen_v, seen_req;
  logic [31:0] first_pc, first_req;

  task automatic reset_dut();
    rst_n = 1'b0;
    id_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    pend.delete(); mbuf.delete();
    mpc = 32'h0; halted = 1'b0; cyc = 0; last_due = -1; n_hs = 0;
    mark = 1'b0; seen_v = 1'b0; seen_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic step(input bit i_idr, input bit i_mrdy, input bit i_redir,
                      input logic [31:0] i_rpc, input bit i_halt);
    bit          rsp_now, exp_rv;
    req_t        r;
    int          due;
    logic [31:0] h;
    id_ready = i_idr; imem_req_ready = i_mrdy;
    redirect_valid = i_redir; redirect_pc = i_rpc; halt = i_halt;
    rsp_now = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? instr_of(pend[0].addr) : 32'h0;
    @(negedge clk);
    exp_rv = !halted && !i_redir && ((pend.size() + mbuf.size()) < DEPTH);
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, mpc);
    check("id_valid", id_valid, mbuf.size() > 0);
    if (mbuf.size() > 0) begin
      h = instr_of(mbuf[0]);
      check("id_pc", id_pc, mbuf[0]);
      check("id_instr", id_instr, h);
      check("id_opcode", id_opcode, h[6:0]);
    end
    if (imem_req_valid && imem_req_ready) n_hs++;
    if (mark && !seen_v && id_valid) begin seen_v = 1'b1; first_pc = id_pc; end
    if (mark && !seen_req && imem_req_valid && imem_req_ready) begin
      seen_req = 1'b1; first_req = imem_req_addr;
    end
    if (rsp_now) r = pend.pop_front();
    if (mbuf.size() > 0 && i_idr && !i_redir) void'(mbuf.pop_front());
    if (rsp_now && !r.stale && !i_redir) mbuf.push_back(r.addr);
    if (i_redir) begin
      mbuf.delete();
      foreach (pend[k]) pend[k].stale = 1'b1;
      mpc = {i_rpc[31:2], 2'b00};
    end else if (exp_rv && i_mrdy) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      pend.push_back('{addr: mpc, due: due, stale: 1'b0});
      last_due = due;
      mpc = mpc + 32'd4;
    end
    if (i_halt) halted = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          idr;
    bit          rv;
    logic [31:0] raddr;
    bit          erv;
    logic [31:0] eaddr;
    bit          eiv;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // Reset release, 1-cycle memory, decode always ready.
    tbl[0] = '{1, 0, 32'h0, 1, 32'h00, 0, 32'h0};
    tbl[1] = '{1, 1, 32'h0, 1, 32'h04, 0, 32'h0};
    tbl[2] = '{1, 1, 32'h4, 0, 32'h00, 1, 32'h0};
    tbl[3] = '{1, 0, 32'h0, 1, 32'h08, 1, 32'h4};
    tbl[4] = '{1, 1, 32'h8, 1, 32'h0C, 0, 32'h0};
    tbl[5] = '{1, 1, 32'hC, 0, 32'h00, 1, 32'h8};
    tbl[6] = '{1, 0, 32'h0, 1, 32'h10, 1, 32'hC};

    lat_min = 1; lat_max = 1;
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      id_ready = tbl[i].idr; imem_req_ready = 1'b1;
      redirect_valid = 1'b0; halt = 1'b0;
      imem_rsp_valid = tbl[i].rv;
      imem_rsp_data  = tbl[i].rv ? instr_of(tbl[i].raddr) : 32'h0;
      @(negedge clk);
      check($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].erv);
      if (tbl[i].erv) check($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].eaddr);
      check($sformatf("tbl%0d_id_valid", i), id_valid, tbl[i].eiv);
      if (tbl[i].eiv) begin
        check($sformatf("tbl%0d_id_pc", i), id_pc, tbl[i].epc);
        check($sformatf("tbl%0d_id_instr", i), id_instr, instr_of(tbl[i].epc));
      end
      @(posedge clk);
      #1;
    end

    // Decode stalled for 5 cycles: at most DEPTH requests, nothing lost.
    reset_dut();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h0, 0);
    check("stall_req_count_le2", n_hs <= 2, 1'b1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h0, 0);

    // Redirect with two requests outstanding on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    reset_dut();
    step(1, 1, 0, 32'h0, 0);
    step(1, 1, 0, 32'h0, 0);
    step(1, 1, 1, 32'h103, 0);
    mark = 1'b1;
    for (int i = 0; i < 20 && !seen_v; i++) step(1, 1, 0, 32'h0, 0);
    check("redir_seen_valid", seen_v, 1'b1);
    check("redir_first_id_pc", first_pc, 32'h100);
    check("redir_first_req", first_req, 32'h100);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 32'h0, 0);

    // Halt once the PC reaches 0x10; afterwards no requests at all.
    lat_min = 2; lat_max = 2;
    reset_dut();
    for (int i = 0; i < 20 && mpc != 32'h10; i++) step(1, 1, 0, 32'h0, 0);
    check("halt_reached_pc10", mpc, 32'h10);
    step(1, 1, 0, 32'h0, 1);
    n_hs = 0;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h0, 0);
    check("halt_no_new_req", n_hs, 0);
    check("halt_buffer_drained", id_valid, 1'b0);

    // Memory not ready for 4 cycles: request held stable (model checks addr).
    lat_min = 1; lat_max = 1;
    reset_dut();
    step(1, 1, 0, 32'h0, 0);
    n_hs = 0;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h0, 0);
    check("notready_no_hs", n_hs, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h0, 0);

    // Reset asserted mid-stream with a full buffer.
    reset_dut();
    for (int i = 0; i < 10 && mbuf.size() < DEPTH; i++) step(0, 1, 0, 32'h0, 0);
    check("full_before_reset", id_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_id_valid", id_valid, 1'b0);
    check("async_rst_req_valid", imem_req_valid, 1'b0);
    @(posedge clk);
    reset_dut();
    step(1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h0, 0);

    // Randomized traffic with variable latency, redirects and occasional halts.
    for (int r = 0; r < 4; r++) begin
      lat_min = 1; lat_max = 1 + r;
      reset_dut();
      for (int i = 0; i < 250; i++) begin
        step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0,
             $urandom, ($urandom % 150) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
